// File: rtl/ctrl_src_arbiter.sv
// Selects one of NUM_SRC control sources onto the set/mode/button bus.
// A guard interval on every source switch keeps spurious pulses off the bus.
module ctrl_src_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MODE_W    = 4,
  parameter int BTN_W     = 4,
  parameter int GUARD_CYC = 4,
  parameter int SEL_W     = 3
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic [SEL_W-1:0]          iSel,
  input  logic [NUM_SRC-1:0]        iSet,
  input  logic [NUM_SRC*MODE_W-1:0] iMode,
  input  logic [NUM_SRC*BTN_W-1:0]  iBtn,
  output logic                      oSet,
  output logic [MODE_W-1:0]         oMode,
  output logic [BTN_W-1:0]          oBtn,
  output logic [SEL_W-1:0]          oSrc,
  output logic                      oBusy
);

  localparam int                CNT_W      = $clog2(GUARD_CYC) + 1;
  localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'(GUARD_CYC - 1);
  localparam logic [SEL_W:0]    NUM_SRC_L  = (SEL_W + 1)'(NUM_SRC);

  typedef enum logic {ACTIVE, GUARD} state_t;

  state_t            state;
  logic [SEL_W-1:0]  target;
  logic [CNT_W-1:0]  guardCnt;
  logic [BTN_W-1:0]  arm;
  logic [BTN_W-1:0]  prevBtn;

  logic              curSet;
  logic [MODE_W-1:0] curMode;
  logic [BTN_W-1:0]  curBtn;
  logic              selValid;

  // Mux the currently active source; oSrc is always a legal index.
  always_comb begin
    curSet  = 1'b0;
    curMode = '0;
    curBtn  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (oSrc == SEL_W'(k)) begin
        curSet  = iSet[k];
        curMode = iMode[k*MODE_W +: MODE_W];
        curBtn  = iBtn[k*BTN_W +: BTN_W];
      end
    end
  end

  assign selValid = ({1'b0, iSel} < NUM_SRC_L);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= ACTIVE;
      target   <= '0;
      guardCnt <= '0;
      arm      <= '0;
      prevBtn  <= '1;
      oSet     <= 1'b0;
      oMode    <= '0;
      oBtn     <= '0;
      oSrc     <= '0;
      oBusy    <= 1'b0;
    end else begin
      case (state)
        ACTIVE: begin
          oSet    <= curSet;
          oMode   <= curMode;
          // A button must be seen low on this source before a rising edge counts.
          oBtn    <= arm & ~prevBtn & curBtn;
          arm     <= arm | ~curBtn;
          prevBtn <= curBtn;
          if (selValid && (iSel != oSrc)) begin
            target   <= iSel;
            guardCnt <= GUARD_LOAD;
            oBusy    <= 1'b1;
            state    <= GUARD;
          end
        end
        GUARD: begin
          oBtn <= '0;
          // Any new valid request (including back to oSrc) restarts the interval.
          if (selValid && (iSel != target)) begin
            target   <= iSel;
            guardCnt <= GUARD_LOAD;
          end else if (guardCnt == '0) begin
            oSrc    <= target;
            arm     <= '0;
            prevBtn <= '1;
            oBusy   <= 1'b0;
            state   <= ACTIVE;
          end else begin
            guardCnt <= guardCnt - CNT_W'(1);
          end
        end
        default: state <= ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_src_arbiter.sv
// Bench for ctrl_src_arbiter: directed vector table, hand-written switch
// sequences, and a randomized run against a behavioural model.
module tb_ctrl_src_arbiter;

  localparam int NS = 3;
  localparam int MW = 4;
  localparam int BW = 4;
  localparam int G  = 4;
  localparam int SW = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic [SW-1:0]    sel;
  logic [NS-1:0]    set;
  logic [NS*MW-1:0] mode;
  logic [NS*BW-1:0] btn;
  logic             oSet;
  logic [MW-1:0]    oMode;
  logic [BW-1:0]    oBtn;
  logic [SW-1:0]    oSrc;
  logic             oBusy;

  int nPass   = 0;
  int nChecks = 0;

  always #5 clk = ~clk;

  ctrl_src_arbiter #(
    .NUM_SRC(NS), .MODE_W(MW), .BTN_W(BW), .GUARD_CYC(G), .SEL_W(SW)
  ) dut (
    .iClk(clk), .iRst_n(rstn), .iSel(sel), .iSet(set), .iMode(mode),
    .iBtn(btn), .oSet(oSet), .oMode(oMode), .oBtn(oBtn), .oSrc(oSrc),
    .oBusy(oBusy)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [2:0]  set;
    logic [11:0] mode;
    logic [11:0] btn;
    logic        eSet;
    logic [3:0]  eMode;
    logic [3:0]  eBtn;
    logic [2:0]  eSrc;
    logic        eBusy;
  } vec_t;

  vec_t vecs[18];

  // Behavioural model: per-button "seen low since activation" and last level.
  int       mSrc, mTarget, mLeft;
  bit       mBusy, mSet;
  bit [3:0] mSeen, mLast, mMode, mBtn;

  function automatic void modelReset();
    mSrc = 0; mTarget = 0; mLeft = 0; mBusy = 0;
    mSeen = '0; mLast = '1; mSet = 0; mMode = '0; mBtn = '0;
  endfunction

  function automatic void modelStep();
    bit lvl;
    if (!mBusy) begin
      for (int b = 0; b < BW; b++) begin
        lvl = btn[mSrc*BW + b];
        mBtn[b] = mSeen[b] && !mLast[b] && lvl;
        if (!lvl) mSeen[b] = 1'b1;
        mLast[b] = lvl;
      end
      mSet  = set[mSrc];
      mMode = mode[mSrc*MW +: MW];
      if (int'(sel) < NS && int'(sel) != mSrc) begin
        mBusy = 1; mTarget = int'(sel); mLeft = G;
      end
    end else begin
      mBtn = '0;
      if (int'(sel) < NS && int'(sel) != mTarget) begin
        mTarget = int'(sel); mLeft = G;
      end else begin
        mLeft = mLeft - 1;
        if (mLeft == 0) begin
          mSrc = mTarget; mBusy = 0; mSeen = '0; mLast = '1;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic checkOuts(input string tag, input logic eSet, input logic [3:0] eMode,
                           input logic [3:0] eBtn, input logic [2:0] eSrc, input logic eBusy);
    chk({tag, ".oSet"},  32'(oSet),  32'(eSet));
    chk({tag, ".oMode"}, 32'(oMode), 32'(eMode));
    chk({tag, ".oBtn"},  32'(oBtn),  32'(eBtn));
    chk({tag, ".oSrc"},  32'(oSrc),  32'(eSrc));
    chk({tag, ".oBusy"}, 32'(oBusy), 32'(eBusy));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int       busyCnt;
    logic [3:0] btnOr;
    logic [2:0] curSel;

    vecs[0]  = '{3'd0, 3'b001, 12'h5A3, 12'h000, 1'b1, 4'h3, 4'h0, 3'd0, 1'b0};
    vecs[1]  = '{3'd0, 3'b001, 12'h5A3, 12'h001, 1'b1, 4'h3, 4'h1, 3'd0, 1'b0};
    vecs[2]  = '{3'd0, 3'b001, 12'h5A3, 12'h001, 1'b1, 4'h3, 4'h0, 3'd0, 1'b0};
    vecs[3]  = '{3'd0, 3'b001, 12'h5A3, 12'h001, 1'b1, 4'h3, 4'h0, 3'd0, 1'b0};
    vecs[4]  = '{3'd0, 3'b001, 12'h5A3, 12'h001, 1'b1, 4'h3, 4'h0, 3'd0, 1'b0};
    vecs[5]  = '{3'd0, 3'b001, 12'h5A3, 12'h001, 1'b1, 4'h3, 4'h0, 3'd0, 1'b0};
    vecs[6]  = '{3'd0, 3'b001, 12'h5A3, 12'h000, 1'b1, 4'h3, 4'h0, 3'd0, 1'b0};
    vecs[7]  = '{3'd5, 3'b001, 12'h5A3, 12'h000, 1'b1, 4'h3, 4'h0, 3'd0, 1'b0};
    vecs[8]  = '{3'd1, 3'b001, 12'h5A3, 12'h082, 1'b1, 4'h3, 4'h2, 3'd0, 1'b1};
    vecs[9]  = '{3'd1, 3'b001, 12'h5A3, 12'h080, 1'b1, 4'h3, 4'h0, 3'd0, 1'b1};
    vecs[10] = '{3'd1, 3'b001, 12'h5A3, 12'h080, 1'b1, 4'h3, 4'h0, 3'd0, 1'b1};
    vecs[11] = '{3'd1, 3'b001, 12'h5A3, 12'h080, 1'b1, 4'h3, 4'h0, 3'd0, 1'b1};
    vecs[12] = '{3'd1, 3'b001, 12'h5A3, 12'h080, 1'b1, 4'h3, 4'h0, 3'd1, 1'b0};
    vecs[13] = '{3'd1, 3'b001, 12'h5A3, 12'h080, 1'b0, 4'hA, 4'h0, 3'd1, 1'b0};
    vecs[14] = '{3'd1, 3'b001, 12'h5A3, 12'h000, 1'b0, 4'hA, 4'h0, 3'd1, 1'b0};
    vecs[15] = '{3'd1, 3'b001, 12'h5A3, 12'h000, 1'b0, 4'hA, 4'h0, 3'd1, 1'b0};
    vecs[16] = '{3'd1, 3'b001, 12'h5A3, 12'h080, 1'b0, 4'hA, 4'h8, 3'd1, 1'b0};
    vecs[17] = '{3'd1, 3'b001, 12'h5A3, 12'h080, 1'b0, 4'hA, 4'h0, 3'd1, 1'b0};

    rstn = 1'b0; sel = '0; set = '0; mode = '0; btn = '0;
    #12;
    checkOuts("reset", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
    rstn = 1'b1;

    // Directed table: pass-through, press, invalid select, switch, lockout.
    for (int i = 0; i < 18; i++) begin
      sel = vecs[i].sel; set = vecs[i].set; mode = vecs[i].mode; btn = vecs[i].btn;
      @(posedge clk); #1;
      checkOuts($sformatf("vec%0d", i), vecs[i].eSet, vecs[i].eMode, vecs[i].eBtn,
                vecs[i].eSrc, vecs[i].eBusy);
    end

    // Asynchronous reset in the middle of a guard interval, then held-button lockout.
    sel = 3'd0; btn = '0;
    @(posedge clk); #1;
    chk("preRst.oBusy", 32'(oBusy), 32'd1);
    #2 rstn = 1'b0;
    #1 checkOuts("asyncRst", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
    btn = 12'h001;
    #2 rstn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk($sformatf("heldAfterRst%0d.oBtn", j), 32'(oBtn), 32'd0);
    end
    chk("heldAfterRst.oSrc", 32'(oSrc), 32'd0);
    btn = 12'h000;
    @(posedge clk); #1;
    chk("relAfterRst.oBtn", 32'(oBtn), 32'd0);
    btn = 12'h001;
    @(posedge clk); #1;
    chk("pressAfterRst.oBtn", 32'(oBtn), 32'd1);
    @(posedge clk); #1;
    chk("holdAfterRst.oBtn", 32'(oBtn), 32'd0);

    // Restart: 0->1, then back to 0 on the second guard cycle.
    btn = '0; sel = 3'd1;
    busyCnt = 0; btnOr = '0;
    @(posedge clk); #1;
    busyCnt += int'(oBusy);
    for (int j = 1; j < 12; j++) begin
      sel = (j >= 2) ? 3'd0 : 3'd1;
      btn = (j <= 5) ? 12'($urandom) : 12'h000;
      @(posedge clk); #1;
      busyCnt += int'(oBusy);
      btnOr |= oBtn;
    end
    chk("restart.busyCycles", 32'(busyCnt), 32'd6);
    chk("restart.oSrc", 32'(oSrc), 32'd0);
    chk("restart.pulses", 32'(btnOr), 32'd0);

    // Invalid select during guard must not restart the interval.
    btn = '0; sel = 3'd1;
    busyCnt = 0;
    @(posedge clk); #1;
    busyCnt += int'(oBusy);
    for (int j = 1; j < 10; j++) begin
      sel = 3'd5;
      @(posedge clk); #1;
      busyCnt += int'(oBusy);
    end
    chk("invGuard.busyCycles", 32'(busyCnt), 32'd4);
    chk("invGuard.oSrc", 32'(oSrc), 32'd1);

    // Randomized run against the behavioural model.
    rstn = 1'b0; sel = '0; btn = '0;
    #2 rstn = 1'b1;
    modelReset();
    checkOuts("rndRst", mSet, mMode, mBtn, 3'(mSrc), mBusy);
    curSel = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) curSel = 3'($urandom_range(0, 7));
      sel  = curSel;
      set  = 3'($urandom);
      mode = 12'($urandom);
      for (int b = 0; b < NS*BW; b++)
        if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
      @(posedge clk);
      modelStep();
      #1;
      checkOuts($sformatf("rnd%0d", n), mSet, mMode, mBtn, 3'(mSrc), mBusy);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
